multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore-style FSM sequencing a shared-ALU, unified-memory multicycle MIPS datapath.
//  Supported subset: LW SW ADD SUB SLT JR ADDI XORI BEQ BNE J JAL.
//  Drives every datapath mux/enable per cycle; stretches memory states on a mem_ready handshake.
//  Keeps free-running cycle and retired-instruction counters for CPU-level benches.
// PARAMETERS
//  CNT_WIDTH        32  width of cycle_count / instr_count
//  HALT_ON_ILLEGAL  1   1: illegal opcode/funct -> HALT until reset; 0: retire as NOP
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high
//  opcode         in   6   IR[31:26], valid from DECODE onward
//  funct          in   6   IR[5:0]
//  zero           in   1   ALU zero flag
//  mem_ready      in   1   memory done this cycle (read data valid / write accepted)
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load if (zero ^ branch_ne)
//  branch_ne      out  1   1 for BNE
//  iord           out  1   memory address: 0=PC, 1=ALUOut
//  mem_read       out  1   memory read request
//  mem_write      out  1   memory write request
//  ir_write       out  1   IR load
//  mem_to_reg     out  2   regfile write data: 00 ALUOut, 01 MDR, 10 PC
//  reg_dst        out  2   regfile write addr: 00 rt, 01 rd, 10 $31
//  reg_write      out  1   regfile write enable
//  alu_src_a      out  1   0=PC, 1=A
//  alu_src_b      out  2   00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  alu_op         out  2   00 add, 01 sub, 10 per funct, 11 xor
//  ext_zero       out  1   1: zero-extend imm16 (XORI), 0: sign-extend
//  pc_source      out  2   00 ALU result, 01 ALUOut, 10 jump target, 11 A (JR)
//  illegal        out  1   unsupported opcode/funct decoded
//  state          out  4   current state, debug
//  cycle_count    out  CNT_WIDTH  clocks since reset; frozen in HALT
//  instr_count    out  CNT_WIDTH  retired instructions
// BEHAVIOUR
//  Reset (async): state=IDLE, counters=0; all outputs 0 in the same timestep. Any pending
//   memory access is abandoned. IDLE -> FETCH on the first clock edge with reset low.
//  Unlisted outputs are 0 in every state.
//  FETCH: mem_read, iord=0, src_a=0, src_b=01, add, pc_source=00.
//   ir_write = pc_write = mem_ready (Mealy). Stays in FETCH until mem_ready.
//  DECODE: src_a=0, src_b=11, add (branch target -> ALUOut). Next state by opcode:
//   23/2B->MEM_ADDR; 00->R_EXEC (funct 20/22/2A), JR (funct 08), else illegal;
//   08/0E->I_EXEC; 04/05->BRANCH; 02->JUMP; 03->JAL; else illegal.
//  MEM_ADDR: src_a=1, src_b=10, add. Next: MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: mem_read, iord=1; wait for mem_ready -> MEM_WB.
//  MEM_WB: reg_write, reg_dst=00, mem_to_reg=01.
//  MEM_WR: mem_write, iord=1; wait for mem_ready -> FETCH.
//  R_EXEC: src_a=1, src_b=00, alu_op=10.  R_WB: reg_write, reg_dst=01, mem_to_reg=00.
//  I_EXEC: src_a=1, src_b=10; ADDI: alu_op=00; XORI: alu_op=11, ext_zero=1.
//   I_WB: reg_write, reg_dst=00; ext_zero/alu_op held as in I_EXEC.
//  BRANCH: src_a=1, src_b=00, sub, pc_write_cond, pc_source=01, branch_ne=(opcode==05).
//  JUMP: pc_write, pc_source=10.  JAL: JUMP outputs + reg_write, reg_dst=10, mem_to_reg=10.
//  JR: pc_write, pc_source=11.  Terminal states return to FETCH.
//  Latency at mem_ready=1: LW 5; SW/R/I 4; BEQ/BNE/J/JAL/JR 3 cycles.
//  Wait states hold all outputs stable. mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
//  Retire: instr_count += 1 on each edge entering FETCH from a terminal state
//   (MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL, JR, or DECODE when illegal and
//   HALT_ON_ILLEGAL=0). Not counted on IDLE->FETCH.
//  Illegal, HALT_ON_ILLEGAL=1: DECODE->HALT; illegal=1 and held; all enables 0;
//   leave only via reset.
//  Illegal, HALT_ON_ILLEGAL=0: illegal pulses 1 in DECODE; DECODE->FETCH, counted as retired.
//  Counters wrap modulo 2^CNT_WIDTH. cycle_count increments every edge except in HALT.
// STRUCTURE
//  Shared header mips_ctl_defs: opcode/funct constants, 4-bit state encodings,
//   alu_op / alu_src_b / pc_source / reg_dst / mem_to_reg codes (shared with ALUControl and muxes).
//  One sub-module: perf_counters (cycle_count, instr_count; inputs retire, halt).
//  FSM: one registered state plus combinational next-state and output decode.
// TESTING
//  reset pulse, then opcode=00, funct=20, mem_ready=1 -> IDLE,FETCH,DECODE,R_EXEC,R_WB,FETCH;
//   R_WB has reg_write=1, reg_dst=01; instr_count 0->1.
//  LW (opcode 23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read/iord
//   stable; 8 cycles FETCH->FETCH; MEM_WB has mem_to_reg=01.
//  BNE (05), zero=0 -> BRANCH has pc_write_cond=1, branch_ne=1, pc_source=01; 3 cycles.
//  JAL (03) -> JAL has pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1; 3 cycles.
//  opcode=3F, HALT_ON_ILLEGAL=1 -> HALT, illegal=1; cycle_count frozen 10 cycles;
//   reset -> IDLE, counters 0.
//  reset asserted mid-MEM_WR (mem_ready=0) -> mem_write=0 same timestep, state=IDLE, counters 0.

Source files
------------

// File: rtl/mips_ctl_defs.sv
// Shared control encodings for the multicycle MIPS datapath: opcodes, functs,
// FSM state codes and the mux/ALU select codes consumed by ALUControl and the datapath muxes.
package mips_ctl_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14,
    S_HALT     = 4'd15
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_XOR = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_A = 2'b11} pc_source_e;
  typedef enum logic [1:0] {RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_e;

  // State following DECODE; S_HALT marks an unsupported opcode/funct.
  function automatic state_e decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    state_e nxt;
    nxt = S_HALT;
    case (opcode)
      OP_LW, OP_SW:     nxt = S_MEM_ADDR;
      OP_ADDI, OP_XORI: nxt = S_I_EXEC;
      OP_BEQ, OP_BNE:   nxt = S_BRANCH;
      OP_J:             nxt = S_JUMP;
      OP_JAL:           nxt = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: nxt = S_R_EXEC;
          FN_JR:                  nxt = S_JR;
          default:                nxt = S_HALT;
        endcase
      end
      default:          nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_perf_counters.sv
// Free-running cycle counter and retired-instruction counter.
// Latency: counts update on the edge where retire/halt are sampled.
// Backpressure: none; cycle counting freezes while halt is high.
module perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 retire,
  input  logic                 halt,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (!halt)  cycle_count <= cycle_count + CNT_ONE;
      if (retire) instr_count <= instr_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-ALU multicycle MIPS datapath (FETCH has Mealy IR/PC load).
// Latency: LW 5, SW/R/I 4, branches/jumps 3 cycles at mem_ready=1.
// Backpressure: FETCH, MEM_RD and MEM_WR stall with outputs held until mem_ready.
module multicycle_control
  import mips_ctl_defs::*;
#(
  parameter int CNT_WIDTH       = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           mem_to_reg,
  output logic [1:0]           reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 ext_zero,
  output logic [1:0]           pc_source,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_e state_q, state_d, decode_tgt;
  logic   decode_illegal, retire, halt;

  // zero is consumed by the datapath's PC enable (pc_write | pc_write_cond & (zero ^ branch_ne)).
  logic unused_zero;
  assign unused_zero = zero;

  assign decode_tgt     = decode_next(opcode, funct);
  assign decode_illegal = (state_q == S_DECODE) && (decode_tgt == S_HALT);
  assign state          = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (decode_tgt != S_HALT)  state_d = decode_tgt;
        else if (HALT_ON_ILLEGAL)  state_d = S_HALT;
        else                       state_d = S_FETCH;
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                  state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    reg_dst       = RDST_RT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    ext_zero      = 1'b0;
    pc_source     = PCSRC_ALU;
    illegal       = decode_illegal;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = RDST_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        ext_zero  = (opcode == OP_XORI);
      end
      S_I_WB: begin
        reg_write = 1'b1;
        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        ext_zero  = (opcode == OP_XORI);
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RDST_RA;
        mem_to_reg = M2R_PC;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_A;
      end
      S_HALT:   illegal = 1'b1;
      default: ;
    endcase
  end

  // Any entry into FETCH other than from IDLE or a FETCH stall completes an instruction.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
  assign halt   = (state_q == S_HALT);

  perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf_counters (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .halt        (halt),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand sequences for illegal-opcode handling and asynchronous reset.
module tb_multicycle_control;
  import mips_ctl_defs::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] exp_state;
    ctl_t       exp_ctl;
    int         exp_icnt;
  } vec_t;

  localparam ctl_t C_ZERO   = '0;
  localparam ctl_t C_FETCH  = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1, pc_write:1'b1, default:'0};
  localparam ctl_t C_FWAIT  = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctl_t C_DEC    = '{alu_src_b:2'b11, default:'0};
  localparam ctl_t C_DECILL = '{alu_src_b:2'b11, illegal:1'b1, default:'0};
  localparam ctl_t C_MADDR  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_MRD    = '{mem_read:1'b1, iord:1'b1, default:'0};
  localparam ctl_t C_MWB    = '{reg_write:1'b1, mem_to_reg:2'b01, default:'0};
  localparam ctl_t C_MWR    = '{mem_write:1'b1, iord:1'b1, default:'0};
  localparam ctl_t C_REX    = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam ctl_t C_RWB    = '{reg_write:1'b1, reg_dst:2'b01, default:'0};
  localparam ctl_t C_XEX    = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, ext_zero:1'b1, default:'0};
  localparam ctl_t C_XWB    = '{reg_write:1'b1, alu_op:2'b11, ext_zero:1'b1, default:'0};
  localparam ctl_t C_AEX    = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_AWB    = '{reg_write:1'b1, default:'0};
  localparam ctl_t C_BNE    = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_source:2'b01, branch_ne:1'b1, default:'0};
  localparam ctl_t C_BEQ    = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_source:2'b01, default:'0};
  localparam ctl_t C_JMP    = '{pc_write:1'b1, pc_source:2'b10, default:'0};
  localparam ctl_t C_JAL    = '{pc_write:1'b1, pc_source:2'b10, reg_write:1'b1, reg_dst:2'b10, mem_to_reg:2'b10, default:'0};
  localparam ctl_t C_JR     = '{pc_write:1'b1, pc_source:2'b11, default:'0};
  localparam ctl_t C_HALT   = '{illegal:1'b1, default:'0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0]  mem_to_reg, reg_dst, alu_src_b, alu_op, pc_source;
  logic        reg_write, alu_src_a, ext_zero, illegal;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  logic        n_pc_write, n_pc_write_cond, n_branch_ne, n_iord, n_mem_read, n_mem_write, n_ir_write;
  logic [1:0]  n_mem_to_reg, n_reg_dst, n_alu_src_b, n_alu_op, n_pc_source;
  logic        n_reg_write, n_alu_src_a, n_ext_zero, n_illegal;
  logic [3:0]  n_state;
  logic [31:0] n_cycle_count, n_instr_count;

  ctl_t act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_zero,
                    pc_source, illegal};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control #(.CNT_WIDTH(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_zero(ext_zero), .pc_source(pc_source), .illegal(illegal),
    .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_WIDTH(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .branch_ne(n_branch_ne), .iord(n_iord),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write), .mem_to_reg(n_mem_to_reg),
    .reg_dst(n_reg_dst), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_op(n_alu_op), .ext_zero(n_ext_zero), .pc_source(n_pc_source), .illegal(n_illegal),
    .state(n_state), .cycle_count(n_cycle_count), .instr_count(n_instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr,
                     input state_e st, input ctl_t c, input int ic);
    vec_t v;
    v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = mr;
    v.exp_state = st; v.exp_ctl = c; v.exp_icnt = ic;
    vecs.push_back(v);
  endtask

  initial begin
    // One row per clock after reset release; opcode in a FETCH row belongs to the next instruction.
    add(6'h00, 6'h20, 0, 1, S_IDLE,     C_ZERO,  0);
    add(6'h00, 6'h20, 0, 1, S_FETCH,    C_FETCH, 0);
    add(6'h00, 6'h20, 0, 1, S_DECODE,   C_DEC,   0);
    add(6'h00, 6'h20, 0, 1, S_R_EXEC,   C_REX,   0);
    add(6'h00, 6'h20, 0, 1, S_R_WB,     C_RWB,   0);
    add(6'h23, 6'h00, 0, 1, S_FETCH,    C_FETCH, 1);
    add(6'h23, 6'h00, 0, 1, S_DECODE,   C_DEC,   1);
    add(6'h23, 6'h00, 0, 1, S_MEM_ADDR, C_MADDR, 1);
    add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_MRD,   1);
    add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_MRD,   1);
    add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_MRD,   1);
    add(6'h23, 6'h00, 0, 1, S_MEM_RD,   C_MRD,   1);
    add(6'h23, 6'h00, 0, 1, S_MEM_WB,   C_MWB,   1);
    add(6'h05, 6'h00, 0, 1, S_FETCH,    C_FETCH, 2);
    add(6'h05, 6'h00, 0, 1, S_DECODE,   C_DEC,   2);
    add(6'h05, 6'h00, 0, 1, S_BRANCH,   C_BNE,   2);
    add(6'h03, 6'h00, 0, 1, S_FETCH,    C_FETCH, 3);
    add(6'h03, 6'h00, 0, 1, S_DECODE,   C_DEC,   3);
    add(6'h03, 6'h00, 0, 1, S_JAL,      C_JAL,   3);
    add(6'h2B, 6'h00, 0, 1, S_FETCH,    C_FETCH, 4);
    add(6'h2B, 6'h00, 0, 1, S_DECODE,   C_DEC,   4);
    add(6'h2B, 6'h00, 0, 1, S_MEM_ADDR, C_MADDR, 4);
    add(6'h2B, 6'h00, 0, 0, S_MEM_WR,   C_MWR,   4);
    add(6'h2B, 6'h00, 0, 1, S_MEM_WR,   C_MWR,   4);
    add(6'h0E, 6'h00, 0, 0, S_FETCH,    C_FWAIT, 5);
    add(6'h0E, 6'h00, 0, 1, S_FETCH,    C_FETCH, 5);
    add(6'h0E, 6'h00, 0, 1, S_DECODE,   C_DEC,   5);
    add(6'h0E, 6'h00, 0, 1, S_I_EXEC,   C_XEX,   5);
    add(6'h0E, 6'h00, 0, 1, S_I_WB,     C_XWB,   5);
    add(6'h00, 6'h08, 0, 1, S_FETCH,    C_FETCH, 6);
    add(6'h00, 6'h08, 0, 1, S_DECODE,   C_DEC,   6);
    add(6'h00, 6'h08, 0, 1, S_JR,       C_JR,    6);
    add(6'h04, 6'h00, 1, 1, S_FETCH,    C_FETCH, 7);
    add(6'h04, 6'h00, 1, 0, S_DECODE,   C_DEC,   7);
    add(6'h04, 6'h00, 1, 1, S_BRANCH,   C_BEQ,   7);
    add(6'h08, 6'h00, 0, 1, S_FETCH,    C_FETCH, 8);
    add(6'h08, 6'h00, 0, 1, S_DECODE,   C_DEC,   8);
    add(6'h08, 6'h00, 0, 1, S_I_EXEC,   C_AEX,   8);
    add(6'h08, 6'h00, 0, 1, S_I_WB,     C_AWB,   8);
    add(6'h02, 6'h00, 0, 1, S_FETCH,    C_FETCH, 9);
    add(6'h02, 6'h00, 0, 1, S_DECODE,   C_DEC,   9);
    add(6'h02, 6'h00, 0, 1, S_JUMP,     C_JMP,   9);
    add(6'h3F, 6'h00, 0, 1, S_FETCH,    C_FETCH, 10);

    // Asynchronous reset: outputs zero before any clock edge.
    #1;
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_ctl", 32'(act_ctl), 32'(C_ZERO));
    chk("reset_cycle_count", cycle_count, 32'd0);
    chk("reset_instr_count", instr_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].opcode; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].mem_ready;
      @(negedge clk);
      chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("row%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].exp_ctl));
      chk($sformatf("row%0d_instr_count", i), instr_count, 32'(vecs[i].exp_icnt));
      chk($sformatf("row%0d_cycle_count", i), cycle_count, 32'(i));
      @(posedge clk);
      #1;
    end

    // Illegal opcode: halting instance freezes, NOP instance retires and continues.
    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    @(negedge clk);
    chk("ill_decode_state", 32'(state), 32'(S_DECODE));
    chk("ill_decode_ctl", 32'(act_ctl), 32'(C_DECILL));
    chk("ill_decode_nop_illegal", 32'(n_illegal), 32'd1);
    @(negedge clk);
    chk("halt_state", 32'(state), 32'(S_HALT));
    chk("halt_ctl", 32'(act_ctl), 32'(C_HALT));
    chk("halt_cycle_count", cycle_count, 32'd44);
    chk("halt_instr_count", instr_count, 32'd10);
    chk("nop_state", 32'(n_state), 32'(S_FETCH));
    chk("nop_instr_count", n_instr_count, 32'd11);
    chk("nop_illegal_pulse", 32'(n_illegal), 32'd0);
    repeat (10) @(negedge clk);
    chk("halt_hold_state", 32'(state), 32'(S_HALT));
    chk("halt_frozen_cycle_count", cycle_count, 32'd44);
    chk("halt_hold_illegal", 32'(illegal), 32'd1);
    chk("halt_hold_instr_count", instr_count, 32'd10);

    reset = 1'b1;
    #1;
    chk("halt_reset_state", 32'(state), 32'(S_IDLE));
    chk("halt_reset_ctl", 32'(act_ctl), 32'(C_ZERO));
    chk("halt_reset_cycle_count", cycle_count, 32'd0);
    chk("halt_reset_instr_count", instr_count, 32'd0);

    // Reset asserted mid-cycle while a store waits on memory.
    @(posedge clk);
    #1 reset = 1'b0; opcode = 6'h2B; mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait_state", 32'(state), 32'(S_MEM_WR));
    chk("sw_wait_mem_write", 32'(mem_write), 32'd1);
    chk("sw_wait_cycle_count", cycle_count, 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("sw_abort_mem_write", 32'(mem_write), 32'd0);
    chk("sw_abort_state", 32'(state), 32'(S_IDLE));
    chk("sw_abort_cycle_count", cycle_count, 32'd0);
    chk("sw_abort_instr_count", instr_count, 32'd0);
    @(negedge clk);
    chk("reset_held_state", 32'(state), 32'(S_IDLE));
    chk("reset_held_cycle_count", cycle_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
